pop_mode_sequencer: RTL and testbench

Parametrised operating-mode sequencer for the POP timing controller, sitting between the button inputs, the POP timer block and the output pins. Debounces the mode button, steps through NUM_MODES operating modes, and drives NUM_CH registered outputs from a per-mode source table. A break-before-make guard forces all outputs low across every mode change, and a blink-code LED shows the active mode as (mode+1) flashes followed by a pause.

---
 rtl/pop_pkg.sv | 32 +++
 rtl/pop_mode_sequencer_if.sv | 24 ++
 rtl/pop_debounce.sv | 39 +++
 rtl/pop_mode_sequencer.sv | 166 ++++++++++++++++
 tb/tb_pop_mode_sequencer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pop_pkg.sv
// Shared constants for the POP mode sequencer: source-select codes, the
// default per-mode channel table and the LED blink-code state type.
package pop_pkg;

  localparam logic [1:0] SRC_LOW   = 2'd0;
  localparam logic [1:0] SRC_HIGH  = 2'd1;
  localparam logic [1:0] SRC_TIMER = 2'd2;
  localparam logic [1:0] SRC_SLOW  = 2'd3;

  typedef enum logic [1:0] {
    LED_ON    = 2'd0,
    LED_OFF   = 2'd1,
    LED_PAUSE = 2'd2
  } led_state_t;

  // One table row per mode; channel c occupies bits [2c+1:2c].
  function automatic logic [7:0] pop_row(input logic [1:0] pump, input logic [1:0] probe,
                                         input logic [1:0] mw, input logic [1:0] sample);
    return {sample, mw, probe, pump};
  endfunction

  localparam logic [55:0] POP_MODE_TABLE_DEFAULT = {
    pop_row(SRC_HIGH,  SRC_HIGH,  SRC_TIMER, SRC_HIGH),   // 6 POP-bypass
    pop_row(SRC_TIMER, SRC_TIMER, SRC_SLOW,  SRC_TIMER),  // 5 pulsed-MW
    pop_row(SRC_TIMER, SRC_TIMER, SRC_LOW,   SRC_TIMER),  // 4 DR
    pop_row(SRC_HIGH,  SRC_LOW,   SRC_LOW,   SRC_LOW),    // 3 pump-cal
    pop_row(SRC_LOW,   SRC_LOW,   SRC_LOW,   SRC_LOW),    // 2 dark
    pop_row(SRC_TIMER, SRC_TIMER, SRC_TIMER, SRC_TIMER),  // 1 POP
    pop_row(SRC_LOW,   SRC_HIGH,  SRC_LOW,   SRC_HIGH)    // 0 setup
  };

endpackage

// File: rtl/pop_mode_sequencer_if.sv
// Signal bundle between the POP mode sequencer (slave) and its surroundings
// (master: button, tick strobe, timer block and output pins).
interface pop_mode_sequencer_if #(
  parameter int NUM_CH    = 4,
  parameter int NUM_MODES = 7
);
  logic                         tick_100us;
  logic                         mode_btn_n;
  logic [NUM_CH-1:0]            timer_ch;
  logic [NUM_CH-1:0]            ch_out;
  logic                         led_out;
  logic [$clog2(NUM_MODES)-1:0] mode;
  logic                         mode_change;

  modport master (
    output tick_100us, mode_btn_n, timer_ch,
    input  ch_out, led_out, mode, mode_change
  );

  modport slave (
    input  tick_100us, mode_btn_n, timer_ch,
    output ch_out, led_out, mode, mode_change
  );
endinterface

// File: rtl/pop_debounce.sv
// Tick-driven run-length debouncer: the level flips after SAMPLES consecutive
// differing samples; press is a combinational strobe on the flipping tick.
module pop_debounce #(
  parameter int SAMPLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(SAMPLES + 1);
  localparam logic [CW-1:0] LAST = CW'(SAMPLES - 1);

  logic [CW-1:0] run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      run   <= '0;
    end else if (tick) begin
      if (raw != level) begin
        if (run == LAST) begin
          level <= raw;
          run   <= '0;
        end else begin
          run <= run + CW'(1);
        end
      end else begin
        run <= '0;
      end
    end
  end

  // Lets the caller act on the same edge that flips the level.
  assign press = tick && raw && !level && (run == LAST);

endmodule

// File: rtl/pop_mode_sequencer.sv
// POP operating-mode sequencer: debounced mode stepping, per-mode output mux,
// blink-code LED and slow square wave. Optional guard: define POP_GUARD_EN.
module pop_mode_sequencer
  import pop_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int NUM_MODES = 7,
  parameter logic [NUM_MODES*NUM_CH*2-1:0] MODE_TABLE = POP_MODE_TABLE_DEFAULT,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int GUARD_TICKS      = 10,
  parameter int FLASH_TICKS      = 1000,
  parameter int PAUSE_TICKS      = 10000,
  parameter int SLOW_TICKS       = 17000
) (
  input logic                 clk_2M5,
  input logic                 rst_n,
  pop_mode_sequencer_if.slave bus
);
  localparam int MW = $clog2(NUM_MODES);
  localparam int LW = $clog2((PAUSE_TICKS > FLASH_TICKS ? PAUSE_TICKS : FLASH_TICKS) + 1);
  localparam int SW = $clog2(SLOW_TICKS + 1);
  localparam logic [MW-1:0] MODE_LAST  = MW'(NUM_MODES - 1);
  localparam logic [LW-1:0] FLASH_LAST = LW'(FLASH_TICKS - 1);
  localparam logic [LW-1:0] PAUSE_LAST = LW'(PAUSE_TICKS - 1);
  localparam logic [SW-1:0] SLOW_LAST  = SW'(SLOW_TICKS - 1);

  logic              unused_btn_level;
  logic              press;
  logic [MW-1:0]     cur_mode;
  logic              mode_pulse;
  logic [SW-1:0]     slow_cnt;
  logic              slow;
  logic              guard_active;
  logic [NUM_CH-1:0] src;
  logic [NUM_CH-1:0] ch_q;
  led_state_t        led_state;
  logic [LW-1:0]     led_cnt;
  logic [MW:0]       flashes;
  logic [MW:0]       flash_target;

  pop_debounce #(.SAMPLES(DEBOUNCE_SAMPLES)) u_debounce (
    .clk   (clk_2M5),
    .rst_n (rst_n),
    .tick  (bus.tick_100us),
    .raw   (~bus.mode_btn_n),
    .level (unused_btn_level),
    .press (press)
  );

  always_ff @(posedge clk_2M5 or negedge rst_n) begin
    if (!rst_n) begin
      cur_mode   <= '0;
      mode_pulse <= 1'b0;
    end else begin
      mode_pulse <= press;
      if (press) cur_mode <= (cur_mode == MODE_LAST) ? '0 : cur_mode + MW'(1);
    end
  end

  always_ff @(posedge clk_2M5 or negedge rst_n) begin
    if (!rst_n) begin
      slow_cnt <= '0;
      slow     <= 1'b0;
    end else if (bus.tick_100us) begin
      if (slow_cnt == SLOW_LAST) begin
        slow_cnt <= '0;
        slow     <= ~slow;
      end else begin
        slow_cnt <= slow_cnt + SW'(1);
      end
    end
  end

`ifdef POP_GUARD_EN
  localparam int GW = $clog2(GUARD_TICKS + 1);
  logic [GW-1:0] guard;

  always_ff @(posedge clk_2M5 or negedge rst_n) begin
    if (!rst_n)                           guard <= GW'(GUARD_TICKS);
    else if (press)                       guard <= GW'(GUARD_TICKS);
    else if (bus.tick_100us && guard != '0) guard <= guard - GW'(1);
  end

  assign guard_active = (guard != '0);
`else
  logic unused_guard_ticks;
  assign unused_guard_ticks = ^GUARD_TICKS;
  assign guard_active       = 1'b0;
`endif

  always_comb begin
    src = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      case (MODE_TABLE[(int'(cur_mode) * NUM_CH + int'(c)) * 2 +: 2])
        SRC_LOW:   src[c] = 1'b0;
        SRC_HIGH:  src[c] = 1'b1;
        SRC_TIMER: src[c] = bus.timer_ch[c];
        default:   src[c] = slow;
      endcase
    end
  end

  always_ff @(posedge clk_2M5 or negedge rst_n) begin
    if (!rst_n)            ch_q <= '0;
    else if (guard_active) ch_q <= '0;
    else                   ch_q <= src;
  end

  assign flash_target = {1'b0, cur_mode} + (MW+1)'(1);

  // A press restarts the blink code from a full pause, overriding any tick.
  always_ff @(posedge clk_2M5 or negedge rst_n) begin
    if (!rst_n) begin
      led_state <= LED_PAUSE;
      led_cnt   <= '0;
      flashes   <= '0;
    end else if (press) begin
      led_state <= LED_PAUSE;
      led_cnt   <= '0;
      flashes   <= '0;
    end else if (bus.tick_100us) begin
      case (led_state)
        LED_ON: begin
          if (led_cnt == FLASH_LAST) begin
            led_state <= LED_OFF;
            led_cnt   <= '0;
            flashes   <= flashes + (MW+1)'(1);
          end else begin
            led_cnt <= led_cnt + LW'(1);
          end
        end
        LED_OFF: begin
          if (led_cnt == FLASH_LAST) begin
            led_cnt <= '0;
            if (flashes == flash_target) begin
              led_state <= LED_PAUSE;
              flashes   <= '0;
            end else begin
              led_state <= LED_ON;
            end
          end else begin
            led_cnt <= led_cnt + LW'(1);
          end
        end
        LED_PAUSE: begin
          if (led_cnt == PAUSE_LAST) begin
            led_state <= LED_ON;
            led_cnt   <= '0;
          end else begin
            led_cnt <= led_cnt + LW'(1);
          end
        end
        default: begin
          led_state <= LED_PAUSE;
          led_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.ch_out      = ch_q;
  assign bus.led_out     = (led_state == LED_ON);
  assign bus.mode        = cur_mode;
  assign bus.mode_change = mode_pulse;

endmodule

// File: tb/tb_pop_mode_sequencer.sv
// Randomized scoreboard bench for pop_mode_sequencer; the reference model
// derives outputs from tick counts since reset / last mode change.
`timescale 1ns/1ps
module tb_pop_mode_sequencer;
  localparam int NUM_CH = 4, NUM_MODES = 7, DEB = 4, GUARD = 10;
  localparam int FLASH = 20, PAUSE = 150, SLOW = 37;
`ifdef POP_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   tick_en = 1'b0;
  always #200 clk = ~clk;

  pop_mode_sequencer_if #(.NUM_CH(NUM_CH), .NUM_MODES(NUM_MODES)) bus ();

  pop_mode_sequencer #(
    .NUM_CH(NUM_CH), .NUM_MODES(NUM_MODES), .DEBOUNCE_SAMPLES(DEB),
    .GUARD_TICKS(GUARD), .FLASH_TICKS(FLASH), .PAUSE_TICKS(PAUSE), .SLOW_TICKS(SLOW)
  ) dut (
    .clk_2M5(clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0] ch;
    logic       led;
    logic [2:0] mode;
    logic       mc;
  } exp_t;

  exp_t exp_q[$];
  int   mode_q[$];
  int   checks = 0, failures = 0, mc_seen = 0;

  // Source per [mode][channel], channels pump, probe, MW, sample:
  // 0 low, 1 high, 2 timer, 3 slow wave.
  int tab [7][4] = '{'{0,1,0,1}, '{2,2,2,2}, '{0,0,0,0}, '{1,0,0,0},
                     '{2,2,0,2}, '{2,2,3,2}, '{1,1,2,1}};

  int   m_mode, m_run, m_nled, m_nslow, m_g;
  bit   m_db, m_press, m_s;
  exp_t e_m, e_mon;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit led_exp(input int n, input int m);
    int on_span, p;
    if (n < PAUSE) return 1'b0;
    on_span = 2 * (m + 1) * FLASH;
    p = (n - PAUSE) % (on_span + PAUSE);
    return (p < on_span) && ((p / FLASH) % 2 == 0);
  endfunction

  function automatic logic [3:0] src_exp(input int m, input logic [3:0] t, input bit s);
    logic [3:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      case (tab[m][c])
        0:       r[c] = 1'b0;
        1:       r[c] = 1'b1;
        2:       r[c] = t[c];
        default: r[c] = s;
      endcase
    end
    return r;
  endfunction

  // Reference model: predicts the outputs that follow the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_run = 0; m_nled = 0; m_nslow = 0; m_g = 0; m_db = 1'b0;
      exp_q.delete();
      mode_q.delete();
    end else begin
      e_m.ch = (GUARD_EN && m_g < GUARD) ? 4'b0000
             : src_exp(m_mode, bus.timer_ch, ((m_nslow / SLOW) % 2) == 1);
      m_press = 1'b0;
      if (bus.tick_100us) begin
        m_s = !bus.mode_btn_n;
        if (m_s != m_db) begin
          m_run++;
          if (m_run == DEB) begin
            m_db = m_s;
            m_run = 0;
            m_press = m_s;
          end
        end else begin
          m_run = 0;
        end
        m_nslow++;
      end
      if (m_press) begin
        m_mode = (m_mode + 1) % NUM_MODES;
        m_g = 0;
        m_nled = 0;
        mode_q.push_back(m_mode);
      end else if (bus.tick_100us) begin
        m_nled++;
        if (m_g < GUARD) m_g++;
      end
      e_m.led  = led_exp(m_nled, m_mode);
      e_m.mode = m_mode[2:0];
      e_m.mc   = m_press;
      exp_q.push_back(e_m);
    end
  end

  // Monitor: compares every presented cycle and every mode_change event.
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      if (exp_q.size() > 0) begin
        e_mon = exp_q.pop_front();
        check("ch_out", bus.ch_out, e_mon.ch);
        check("led_out", bus.led_out, e_mon.led);
        check("mode", bus.mode, e_mon.mode);
        check("mode_change", bus.mode_change, e_mon.mc);
      end
      if (bus.mode_change) begin
        mc_seen++;
        check("mode_change_event", bus.mode_change, mode_q.size() > 0);
        if (mode_q.size() > 0) check("event_mode", bus.mode, mode_q.pop_front());
      end
    end
  end

  // Tick strobe and timer-channel stimulus.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus.tick_100us = tick_en && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) bus.timer_ch = 4'($urandom);
    end
  end

  task automatic hold(input logic v, input int n);
    int cnt = 0;
    int cyc = 0;
    bus.mode_btn_n = v;
    while (cnt < n && cyc < n * 60 + 100) begin
      @(posedge clk);
      cyc++;
      if (bus.tick_100us) cnt++;
    end
    if (cnt < n) check("tick_budget", cnt, n);
    #1;
  endtask

  int mc0, k;

  initial begin
    bus.tick_100us = 1'b0;
    bus.mode_btn_n = 1'b1;
    bus.timer_ch   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ch_out", bus.ch_out, 0);
    check("reset_led_out", bus.led_out, 0);
    check("reset_mode", bus.mode, 0);
    check("reset_mode_change", bus.mode_change, 0);
    rst_n   = 1'b1;
    tick_en = 1'b1;

    hold(1'b1, GUARD + 5);
    check("mode0_sources", bus.ch_out, 4'b1010);

    hold(1'b0, DEB - 1);
    hold(1'b1, 10);
    check("short_press_mode", bus.mode, 0);

    mc0 = mc_seen;
    hold(1'b0, DEB);
    check("advance_mode", bus.mode, 1);
    hold(1'b0, 50);
    check("held_mode", bus.mode, 1);
    check("held_one_pulse", mc_seen - mc0, 1);
    hold(1'b1, 6);

    hold(1'b0, DEB);
    hold(1'b1, DEB);
    hold(1'b0, DEB);
    check("guard_repress_mode", bus.mode, 3);
    hold(1'b1, GUARD + 4);
    check("mode3_sources", bus.ch_out, 4'b0001);

    mc0 = mc_seen;
    for (int i = 0; i < 7; i++) begin
      hold(1'b0, $urandom_range(DEB, DEB + 4));
      check("step_mode", bus.mode, (4 + i) % 7);
      hold(1'b1, $urandom_range(DEB, DEB + 12));
    end
    check("wrap_mode", bus.mode, 3);
    check("wrap_pulses", mc_seen - mc0, 7);

    repeat (40) begin
      hold(1'b0, $urandom_range(1, 7));
      hold(1'b1, $urandom_range(1, 7));
    end
    hold(1'b1, DEB + 1);

    k = 0;
    while (m_mode != 2 && k < 8) begin
      hold(1'b0, DEB);
      hold(1'b1, DEB);
      k++;
    end
    check("led_mode", bus.mode, 2);
    // Run one whole code period, then stop in the second flash of the next.
    hold(1'b1, 2 * PAUSE + 8 * FLASH + FLASH / 2 - m_nled);
    check("flash2_led", bus.led_out, 1);

    #50 rst_n = 1'b0;
    #1;
    check("midrun_reset_led", bus.led_out, 0);
    check("midrun_reset_mode", bus.mode, 0);
    check("midrun_reset_ch", bus.ch_out, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    hold(1'b1, PAUSE + 2 * FLASH + 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(64'd400 * 64'd60000);
    $display("FAIL watchdog cycles_run=60000 required_below=60000");
    $fatal(1, "watchdog expired");
  end

endmodule
